apb_cmd_master: RTL and testbench
=================================

// Module: apb_cmd_master
//
// PURPOSE
//   APB initiator: turns a simple valid/ready command into one APB transfer.
//   It drives the timer's tim_p* slave interface (or any APB slave).
//   It returns read data and error status on a valid/ready response channel.
//   Used by the on-chip sequencer and the test harness to program the timer
//   (TCR, TDR0/1, TCMP, TIER, TISR).
//
// PARAMETERS
//   ADDR_W       12  APB address width
//   DATA_W       32  APB data width; strobe width is DATA_W/8
//   TIMEOUT_CYC  16  max ACCESS cycles before abort (only with APB_MST_TIMEOUT_EN)
//
// PORTS
//   sys_clk      in   1         clock; all logic on rising edge
//   sys_rst_n    in   1         reset, synchronous, active-low
//   cmd_valid    in   1         command request
//   cmd_ready    out  1         command accepted when cmd_valid & cmd_ready
//   cmd_write    in   1         1=write, 0=read
//   cmd_addr     in   ADDR_W    target address
//   cmd_wdata    in   DATA_W    write data
//   cmd_strb     in   DATA_W/8  write byte strobes
//   rsp_valid    out  1         response available
//   rsp_ready    in   1         response consumed when rsp_valid & rsp_ready
//   rsp_rdata    out  DATA_W    read data; 0 for writes and errors
//   rsp_err      out  1         slave PSLVERR (or timeout)
//   m_psel       out  1         APB PSEL
//   m_penable    out  1         APB PENABLE
//   m_pwrite     out  1         APB PWRITE
//   m_paddr      out  ADDR_W    APB PADDR
//   m_pwdata     out  DATA_W    APB PWDATA
//   m_pstrb      out  DATA_W/8  APB PSTRB
//   m_pready     in   1         APB PREADY
//   m_pslverr    in   1         APB PSLVERR
//   m_prdata     in   DATA_W    APB PRDATA
//
// BEHAVIOUR
//   FSM states: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//   All outputs are registered or decoded from the state register.
//   Reset (sys_rst_n=0 at an edge):
//     - state=IDLE; m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, m_pstrb = 0.
//     - rsp_valid=0, rsp_rdata=0, rsp_err=0.
//     - cmd_ready = (state==IDLE) & sys_rst_n, so it is 0 while reset is held.
//   IDLE:
//     - cmd_ready=1.
//     - On accept, latch write/addr/wdata/strb; next state SETUP.
//   SETUP (exactly 1 cycle):
//     - psel=1, penable=0.
//     - paddr/pwrite/pwdata/pstrb driven from latched values.
//     - pstrb forced to 0 on reads.
//   ACCESS:
//     - psel=1, penable=1; all address/control/data held stable.
//     - Stays while m_pready=0.
//     - On m_pready=1: capture m_prdata (reads only) and m_pslverr; go to RESP.
//   RESP:
//     - psel=penable=0; rsp_valid=1, with rsp_rdata/rsp_err held.
//     - On rsp_ready=1: rsp_valid=0 next cycle, go to IDLE.
//     - If rsp_ready=1 is already high on entry, the response lasts 1 cycle.
//   Latency: accept at cycle N, SETUP N+1, ACCESS N+2.
//     - With zero-wait pready, rsp_valid rises at N+3.
//     - Each wait state adds 1 cycle.
//     - Minimum 4 cycles per command, including the IDLE cycle.
//   Error: m_pslverr=1 with pready gives rsp_err=1 and rsp_rdata=0.
//   Reset mid-transfer: the next edge returns to IDLE and psel drops.
//     No response is produced and the latched command is discarded.
//   cmd_* inputs are ignored outside IDLE; rsp_ready is ignored outside RESP.
//   m_paddr is passed through unmodified, aligned or not; decode is the slave's job.
//
// CONFIGURATION
//   APB_MST_TIMEOUT_EN defined:
//     - A $clog2(TIMEOUT_CYC+1)-bit counter clears on SETUP and counts each
//       ACCESS cycle with pready=0.
//     - When it reaches TIMEOUT_CYC, the FSM aborts to RESP with rsp_err=1 and
//       rsp_rdata=0; psel/penable drop.
//     - A late pready after the abort is ignored.
//   APB_MST_TIMEOUT_EN not defined:
//     - No counter; ACCESS waits indefinitely for pready.
//     - TIMEOUT_CYC is unused.
//
// TESTING
//   1. Write, zero-wait slave: cmd addr=0x004, wdata=0x0000_00FF, strb=0xF
//      -> SETUP at N+1, ACCESS at N+2 with those values; rsp_valid at N+3 with rsp_err=0.
//   2. Read, 3 wait states, prdata=0x1234_5678 -> penable high for 4 cycles,
//      pstrb=0; rsp_rdata=0x1234_5678 at N+6.
//   3. Slave error (pslverr=1 with pready) on write to 0xFFC -> rsp_err=1, rsp_rdata=0.
//   4. Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid, rsp_rdata, rsp_err stable;
//      cmd_ready=0 throughout; IDLE the cycle after rsp_ready=1.
//   5. sys_rst_n=0 for 1 cycle during ACCESS -> psel=penable=0 next cycle;
//      no rsp_valid; next command runs normally.
//   6. (APB_MST_TIMEOUT_EN) pready stuck low, TIMEOUT_CYC=16 -> abort after
//      16 ACCESS cycles with rsp_err=1; a later pready pulse has no effect.

Source files
------------

// File: rtl/apb_cmd_master.sv
// APB initiator: one valid/ready command becomes one APB transfer, and the result comes back on a valid/ready response.
// Define APB_MST_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYC cycles in which the slave never asserts pready.
module apb_cmd_master #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                m_psel,
  output logic                m_penable,
  output logic                m_pwrite,
  output logic [ADDR_W-1:0]   m_paddr,
  output logic [DATA_W-1:0]   m_pwdata,
  output logic [DATA_W/8-1:0] m_pstrb,
  input  logic                m_pready,
  input  logic                m_pslverr,
  input  logic [DATA_W-1:0]   m_prdata
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state;
  logic   tmo_hit;

  assign cmd_ready = (state == IDLE) & sys_rst_n;

`ifdef APB_MST_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] tmo_cnt;

  // Abort on the TIMEOUT_CYC-th ACCESS cycle that still has no pready.
  assign tmo_hit = !m_pready && (tmo_cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n)                        tmo_cnt <= '0;
    else if (state == SETUP)               tmo_cnt <= '0;
    else if (state == ACCESS && !m_pready) tmo_cnt <= tmo_cnt + CW'(1);
  end
`else
  // This term is always false, so the timeout path is removed from the logic.
  assign tmo_hit = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      m_psel    <= 1'b0;
      m_penable <= 1'b0;
      m_pwrite  <= 1'b0;
      m_paddr   <= '0;
      m_pwdata  <= '0;
      m_pstrb   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          state     <= SETUP;
          m_psel    <= 1'b1;
          m_penable <= 1'b0;
          m_pwrite  <= cmd_write;
          m_paddr   <= cmd_addr;
          m_pwdata  <= cmd_wdata;
          m_pstrb   <= cmd_write ? cmd_strb : '0;
        end
        SETUP: begin
          state     <= ACCESS;
          m_penable <= 1'b1;
        end
        ACCESS: if (m_pready || tmo_hit) begin
          state     <= RESP;
          m_psel    <= 1'b0;
          m_penable <= 1'b0;
          rsp_valid <= 1'b1;
          if (m_pready) begin
            rsp_err   <= m_pslverr;
            rsp_rdata <= (!m_pwrite && !m_pslverr) ? m_prdata : '0;
          end else begin
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end
        end
        RESP: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Scoreboarded bench for apb_cmd_master, driven by a configurable APB slave model.
module tb_apb_cmd_master;
  localparam int AW = 12, DW = 32, TMO = 16;

  logic          sys_clk = 0, sys_rst_n = 0;
  logic          cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [3:0]    cmd_strb = '0;
  logic          rsp_valid, rsp_ready = 1, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          m_psel, m_penable, m_pwrite, m_pready, m_pslverr;
  logic [AW-1:0] m_paddr;
  logic [DW-1:0] m_pwdata, m_prdata;
  logic [3:0]    m_pstrb;

  apb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite), .m_paddr(m_paddr),
    .m_pwdata(m_pwdata), .m_pstrb(m_pstrb), .m_pready(m_pready),
    .m_pslverr(m_pslverr), .m_prdata(m_prdata));

  always #5 sys_clk = ~sys_clk;

  // Slave model: pready after wait_n wait states, unless stuck (then only late_pulse drives it).
  int          wait_n = 0, acc_cnt = 0;
  bit          stuck = 0, late_pulse = 0, slv_err = 0;
  logic [DW-1:0] slv_rdata = '0;
  assign m_pready  = stuck ? late_pulse : (m_psel && m_penable && acc_cnt == wait_n);
  assign m_pslverr = slv_err;
  assign m_prdata  = slv_rdata;
  always @(posedge sys_clk)
    acc_cnt <= (m_psel && m_penable && !m_pready) ? acc_cnt + 1 : 0;

  int checks = 0, failures = 0;
  logic [DW:0] sb[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Responses are compared on the negedge before the accepting posedge.
  always @(negedge sys_clk)
    if (sys_rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        logic [DW:0] e;
        e = sb.pop_front();
        chk("rsp_err", rsp_err, e[DW]);
        chk("rsp_rdata", rsp_rdata, e[DW-1:0]);
      end
    end

  task automatic tick;
    @(posedge sys_clk); #1;
  endtask

  // Issues one command from IDLE and returns in the first RESP cycle.
  task automatic run_cmd(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [3:0] sb_in, input int waits, input logic [DW-1:0] rd,
                         input bit er, input bit tmo);
    int lat;
    wait_n = waits; slv_rdata = rd; slv_err = er;
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = wd; cmd_strb = sb_in;
    chk("cmd_ready_idle", cmd_ready, 1);
    if (tmo) sb.push_back({1'b1, 32'h0});
    else     sb.push_back({er, (!w && !er) ? rd : 32'h0});
    tick; lat = 1;
    cmd_valid = 0; cmd_wdata = $urandom; cmd_addr = AW'($urandom);
    chk("setup_sel_en", {m_psel, m_penable}, 2'b10);
    chk("setup_paddr", m_paddr, a);
    chk("setup_pwrite", m_pwrite, w);
    chk("setup_pwdata", m_pwdata, wd);
    chk("setup_pstrb", m_pstrb, w ? sb_in : 4'h0);
    chk("setup_cmd_ready", cmd_ready, 0);
    tick; lat++;
    while (m_penable && lat < 200) begin
      chk("access_stable", {m_psel, m_pwrite, m_paddr, m_pwdata, m_pstrb},
          {1'b1, w, a, wd, w ? sb_in : 4'h0});
      tick; lat++;
    end
    chk("access_cycles", lat - 2, tmo ? TMO : waits + 1);
    chk("rsp_valid_rise", rsp_valid, 1);
    chk("resp_sel_en", {m_psel, m_penable}, 2'b00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tick; tick;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_apb", {m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, m_pstrb}, '0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, '0);
    sys_rst_n = 1;
    tick;

    // 1: zero-wait write
    run_cmd(1, 12'h004, 32'h0000_00FF, 4'hF, 0, 32'hDEAD_BEEF, 0, 0);
    tick;
    chk("t1_idle", {cmd_ready, rsp_valid}, 2'b10);

    // 2: read with 3 wait states
    run_cmd(0, 12'h010, 32'hAAAA_5555, 4'hF, 3, 32'h1234_5678, 0, 0);
    tick;

    // 3: slave error on write and on read
    run_cmd(1, 12'hFFC, 32'h1111_2222, 4'h3, 0, 32'h5A5A_5A5A, 1, 0);
    tick;
    run_cmd(0, 12'h008, 32'h0, 4'hF, 2, 32'h7777_8888, 1, 0);
    tick;

    // 4: response backpressure
    rsp_ready = 0;
    run_cmd(0, 12'h00C, 32'h0, 4'h1, 1, 32'hCAFE_0001, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {rsp_valid, rsp_err, rsp_rdata, cmd_ready}, {1'b1, 1'b0, 32'hCAFE_0001, 1'b0});
      tick;
    end
    rsp_ready = 1;
    tick;
    chk("bp_release", {cmd_ready, rsp_valid}, 2'b10);

    // 5: reset during ACCESS
    wait_n = 6; slv_rdata = 32'h0BAD_0BAD; slv_err = 0;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 12'h014;
    tick; cmd_valid = 0;
    tick; tick;
    chk("pre_rst_access", {m_psel, m_penable}, 2'b11);
    sys_rst_n = 0;
    tick;
    chk("midrst_cmd_ready", cmd_ready, 0);
    chk("midrst_apb", {m_psel, m_penable}, 2'b00);
    sys_rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      chk("midrst_no_rsp", rsp_valid, 0);
      tick;
    end
    run_cmd(1, 12'h003, 32'h8765_4321, 4'h5, 0, 32'h0, 0, 0);
    tick;

    // A few random transfers, with unaligned addresses allowed
    for (int i = 0; i < 6; i++) begin
      run_cmd(1'($urandom), AW'($urandom), $urandom, 4'($urandom), $urandom_range(0, 4),
              $urandom, ($urandom_range(0, 3) == 0), 0);
      tick;
      chk("rand_idle", cmd_ready, 1);
    end

`ifdef APB_MST_TIMEOUT_EN
    // 6: stuck slave gets aborted; a late pready has no effect
    stuck = 1; rsp_ready = 0;
    run_cmd(0, 12'h020, 32'h0, 4'hF, 0, 32'hFFFF_0000, 0, 1);
    late_pulse = 1;
    tick;
    late_pulse = 0;
    chk("tmo_hold", {rsp_valid, rsp_err, rsp_rdata, m_psel}, {1'b1, 1'b1, 32'h0, 1'b0});
    rsp_ready = 1;
    tick;
    stuck = 0;
    chk("tmo_idle", {cmd_ready, rsp_valid}, 2'b10);
    run_cmd(0, 12'h024, 32'h0, 4'hF, 1, 32'h0000_ABCD, 0, 0);
    tick;
`endif

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
